// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;
  localparam logic [1:0] PC_SRC_RSV = 2'b11;

  localparam logic [XLEN-1:0] NOP_INST = XLEN'(0);

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and imem.
interface if_stage_if;
  import if_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble load wins over a normal write.
module ifid_reg
  import if_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  localparam ifid_t BUBBLE = '{inst: NOP_INST, pc4: XLEN'(0), valid: 1'b0};

  ifid_t ifid_d, ifid_q;

  always_comb begin
    ifid_d = ifid_q;
    if (bubble)  ifid_d = BUBBLE;
    else if (we) ifid_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifid_q <= BUBBLE;
    else        ifid_q <= ifid_d;
  end

  assign q = ifid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem handshake, stall hold buffer and redirect drain.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            IFID_write,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] IFID_inst,
  output logic [XLEN-1:0] IFID_pc4,
  output logic            IFID_valid
);

  state_e          state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] hold_d, hold_q;
  logic [XLEN-1:0] redir_d, redir_q;
  logic            req_d, req_q;

  logic            redirect, stall;
  logic [XLEN-1:0] target, pc_plus4;
  logic            ifid_we, ifid_bubble;
  ifid_t           ifid_in, ifid_out;

  assign redirect = (pc_src == PC_SRC_BR) || (pc_src == PC_SRC_J);
  assign target   = (pc_src == PC_SRC_J) ? jump_target : branch_target;
  assign stall    = !(IFID_write && pc_write);
  assign pc_plus4 = pc_q + XLEN'(4);

  // Next-state, PC and IF/ID load control; redirect always beats stall.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    redir_d     = redir_q;
    ifid_we     = 1'b0;
    ifid_bubble = 1'b0;
    ifid_in     = '{inst: imem.imem_rdata, pc4: pc_plus4, valid: 1'b1};

    unique case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          ifid_bubble = 1'b1;
          if (imem.imem_ready) begin
            pc_d = target;
          end else begin
            redir_d = target;
            state_d = ST_DRAIN;
          end
        end else if (imem.imem_ready) begin
          if (!stall) begin
            ifid_we = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          hold_d      = XLEN'(0);
          pc_d        = target;
          ifid_bubble = 1'b1;
          state_d     = ST_FETCH;
        end else if (!stall) begin
          ifid_in.inst = hold_q;
          ifid_we      = 1'b1;
          pc_d         = pc_plus4;
          state_d      = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        ifid_bubble = IFID_write;
        if (redirect) redir_d = target;
        // The stale response is dropped; a same-cycle redirect supersedes the saved one.
        if (imem.imem_ready) begin
          pc_d    = redirect ? target : redir_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase

    req_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= XLEN'(0);
      redir_q <= XLEN'(0);
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      redir_q <= redir_d;
      req_q   <= req_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (ifid_we),
    .bubble (ifid_bubble),
    .d      (ifid_in),
    .q      (ifid_out)
  );

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign IFID_inst      = ifid_out.inst;
  assign IFID_pc4       = ifid_out.pc4;
  assign IFID_valid     = ifid_out.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; imem returns addr ^ 32'hDEAD_BEEF.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, IFID_write;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target;
  logic [31:0] IFID_inst, IFID_pc4;
  logic        IFID_valid;
  int          total = 0;
  int          passed = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IFID_write(IFID_write),
    .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
    .imem(bus), .IFID_inst(IFID_inst), .IFID_pc4(IFID_pc4), .IFID_valid(IFID_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign bus.imem_rdata = mem(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; pc_write = 1'b1; IFID_write = 1'b1; pc_src = PC_SRC_SEQ;
    branch_target = 32'h0; jump_target = 32'h0; bus.imem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; pc_write = 1'b1; IFID_write = 1'b1; pc_src = PC_SRC_SEQ;
    branch_target = 32'h0; jump_target = 32'h0; bus.imem_ready = 1'b0;
    #1;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr got %h exp %h", bus.imem_addr, 32'h0); else passed++;
    total++; if (bus.imem_req !== 1'b1) $display("FAIL reset_req got %b exp 1", bus.imem_req); else passed++;
    total++; if (IFID_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", IFID_valid); else passed++;
    total++; if (IFID_inst !== 32'h0) $display("FAIL reset_inst got %h exp 0", IFID_inst); else passed++;
    total++; if (IFID_pc4 !== 32'h0) $display("FAIL reset_pc4 got %h exp 0", IFID_pc4); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc4;
    do_reset();
    bus.imem_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc4 = 32'(i * 4);
      total++; if (IFID_pc4 !== exp_pc4) $display("FAIL seq_pc4[%0d] got %h exp %h", i, IFID_pc4, exp_pc4); else passed++;
      total++; if (IFID_inst !== mem(exp_pc4 - 32'd4)) $display("FAIL seq_inst[%0d] got %h exp %h", i, IFID_inst, mem(exp_pc4 - 32'd4)); else passed++;
      total++; if (bus.imem_addr !== exp_pc4) $display("FAIL seq_addr[%0d] got %h exp %h", i, bus.imem_addr, exp_pc4); else passed++;
    end
  endtask

  task automatic test_wait();
    do_reset();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0; IFID_write = 1'b0;
    tick();
    total++; if (IFID_pc4 !== 32'd4 || IFID_valid !== 1'b1) $display("FAIL wait_stall_held got pc4=%h v=%b exp 4/1", IFID_pc4, IFID_valid); else passed++;
    total++; if (bus.imem_addr !== 32'd4) $display("FAIL wait_stall_addr got %h exp 4", bus.imem_addr); else passed++;
    IFID_write = 1'b1;
    tick();
    total++; if (IFID_valid !== 1'b0 || IFID_pc4 !== 32'h0) $display("FAIL wait_bubble got pc4=%h v=%b exp 0/0", IFID_pc4, IFID_valid); else passed++;
    total++; if (bus.imem_addr !== 32'd4) $display("FAIL wait_addr got %h exp 4", bus.imem_addr); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    bus.imem_ready = 1'b1;
    tick(); tick();
    IFID_write = 1'b0; pc_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (dut.state_q !== ST_HOLD) $display("FAIL stall_state[%0d] got %0d exp %0d", i, dut.state_q, ST_HOLD); else passed++;
      total++; if (bus.imem_req !== 1'b0) $display("FAIL stall_req[%0d] got %b exp 0", i, bus.imem_req); else passed++;
      total++; if (IFID_pc4 !== 32'd8 || IFID_inst !== mem(32'd4)) $display("FAIL stall_held[%0d] got %h/%h exp %h/%h", i, IFID_inst, IFID_pc4, mem(32'd4), 32'd8); else passed++;
    end
    IFID_write = 1'b1; pc_write = 1'b1; bus.imem_ready = 1'b0;
    tick();
    total++; if (IFID_inst !== mem(32'd8)) $display("FAIL stall_rel_inst got %h exp %h", IFID_inst, mem(32'd8)); else passed++;
    total++; if (IFID_pc4 !== 32'd12 || IFID_valid !== 1'b1) $display("FAIL stall_rel_pc4 got %h/%b exp %h/1", IFID_pc4, IFID_valid, 32'd12); else passed++;
    total++; if (bus.imem_addr !== 32'd12 || bus.imem_req !== 1'b1) $display("FAIL stall_rel_addr got %h/%b exp %h/1", bus.imem_addr, bus.imem_req, 32'd12); else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    bus.imem_ready = 1'b1;
    repeat (4) tick();
    total++; if (bus.imem_addr !== 32'd16) $display("FAIL br_setup_addr got %h exp %h", bus.imem_addr, 32'd16); else passed++;
    pc_src = PC_SRC_BR; branch_target = 32'h40;
    tick();
    total++; if (IFID_valid !== 1'b0 || IFID_inst !== 32'h0) $display("FAIL br_bubble got %h/%b exp 0/0", IFID_inst, IFID_valid); else passed++;
    total++; if (bus.imem_addr !== 32'h40) $display("FAIL br_addr got %h exp %h", bus.imem_addr, 32'h40); else passed++;
    pc_src = PC_SRC_SEQ;
    tick();
    total++; if (IFID_pc4 !== 32'h44 || IFID_inst !== mem(32'h40)) $display("FAIL br_next got %h/%h exp %h/%h", IFID_inst, IFID_pc4, mem(32'h40), 32'h44); else passed++;
  endtask

  task automatic test_jump_drain();
    do_reset();
    bus.imem_ready = 1'b1;
    repeat (5) tick();
    bus.imem_ready = 1'b0; pc_src = PC_SRC_J; jump_target = 32'h100;
    tick();
    total++; if (dut.state_q !== ST_DRAIN) $display("FAIL jd_state got %0d exp %0d", dut.state_q, ST_DRAIN); else passed++;
    pc_src = PC_SRC_SEQ;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.imem_addr !== 32'd20 || bus.imem_req !== 1'b1) $display("FAIL jd_addr[%0d] got %h/%b exp %h/1", i, bus.imem_addr, bus.imem_req, 32'd20); else passed++;
      tick();
    end
    total++; if (IFID_valid !== 1'b0) $display("FAIL jd_bubble got %b exp 0", IFID_valid); else passed++;
    bus.imem_ready = 1'b1;
    tick();
    total++; if (bus.imem_addr !== 32'h100 || IFID_valid !== 1'b0) $display("FAIL jd_drop got %h/%b exp %h/0", bus.imem_addr, IFID_valid, 32'h100); else passed++;
    tick();
    total++; if (IFID_pc4 !== 32'h104 || IFID_inst !== mem(32'h100)) $display("FAIL jd_next got %h/%h exp %h/%h", IFID_inst, IFID_pc4, mem(32'h100), 32'h104); else passed++;
  endtask

  task automatic test_hold_redirect();
    do_reset();
    bus.imem_ready = 1'b1; IFID_write = 1'b0; pc_write = 1'b0;
    tick();
    pc_src = PC_SRC_BR; branch_target = 32'h80;
    tick();
    total++; if (dut.state_q !== ST_FETCH || IFID_valid !== 1'b0) $display("FAIL hr_state got %0d/%b exp %0d/0", dut.state_q, IFID_valid, ST_FETCH); else passed++;
    total++; if (bus.imem_addr !== 32'h80) $display("FAIL hr_addr got %h exp %h", bus.imem_addr, 32'h80); else passed++;
    pc_src = PC_SRC_SEQ; IFID_write = 1'b1; pc_write = 1'b1;
    tick();
    total++; if (IFID_inst !== mem(32'h80) || IFID_pc4 !== 32'h84) $display("FAIL hr_next got %h/%h exp %h/%h", IFID_inst, IFID_pc4, mem(32'h80), 32'h84); else passed++;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    bus.imem_ready = 1'b1; pc_src = PC_SRC_J; jump_target = 32'hFFFF_FFFC;
    tick();
    pc_src = PC_SRC_SEQ;
    tick();
    total++; if (IFID_pc4 !== 32'h0 || IFID_valid !== 1'b1) $display("FAIL wrap_pc4 got %h/%b exp 0/1", IFID_pc4, IFID_valid); else passed++;
    total++; if (IFID_inst !== mem(32'hFFFF_FFFC)) $display("FAIL wrap_inst got %h exp %h", IFID_inst, mem(32'hFFFF_FFFC)); else passed++;
    total++; if (bus.imem_addr !== 32'h0) $display("FAIL wrap_addr got %h exp 0", bus.imem_addr); else passed++;
    tick();
    bus.imem_ready = 1'b0; pc_src = PC_SRC_J; jump_target = 32'h200;
    tick();
    total++; if (dut.state_q !== ST_DRAIN || bus.imem_addr !== 32'd4) $display("FAIL rst_pre_drain got %0d/%h exp %0d/%h", dut.state_q, bus.imem_addr, ST_DRAIN, 32'd4); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.imem_addr !== 32'h0 || dut.state_q !== ST_FETCH) $display("FAIL rst_async got %h/%0d exp 0/%0d", bus.imem_addr, dut.state_q, ST_FETCH); else passed++;
    @(negedge clk);
    rst_n = 1'b1; pc_src = PC_SRC_SEQ; bus.imem_ready = 1'b1;
    tick();
    total++; if (IFID_pc4 !== 32'd4 || IFID_inst !== mem(32'h0)) $display("FAIL rst_refetch got %h/%h exp %h/%h", IFID_inst, IFID_pc4, mem(32'h0), 32'd4); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_branch();
    test_jump_drain();
    test_hold_redirect();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pc_write  input  1  from hazard unit; 0 = PC stall.
REQ-005 SHALL have port IFID_write  input  1  from hazard unit; 0 = IF/ID hold.
REQ-006 SHALL have port pc_src  input  2  00 sequential, 01 branch, 10 jump, 11 reserved (treated as 00).
REQ-007 SHALL have ports branch_target and jump_target, each input  32  redirect addresses.
REQ-008 SHALL have ports imem_req output 1, imem_addr output 32, imem_ready input 1 and imem_rdata input 32, forming the instruction-memory handshake.
REQ-009 SHALL have ports IFID_inst output 32, IFID_pc4 output 32 and IFID_valid output 1, forming the IF/ID register outputs.

Function
REQ-010 SHALL define redirect = (pc_src==01 || pc_src==10); target = branch_target for 01, jump_target for 10.
REQ-011 SHALL define stall = !(IFID_write && pc_write); redirect SHALL take priority over stall.
REQ-012 SHALL implement states FETCH, HOLD and DRAIN.
REQ-013 In FETCH, SHALL drive imem_req=1 and imem_addr=pc; imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-014 In FETCH with imem_ready=1, !redirect and !stall: IF/ID <= {imem_rdata, pc+4, valid=1}, pc <= pc+4, remain in FETCH.
REQ-015 In FETCH with imem_ready=1, !redirect and stall: imem_rdata goes to the hold buffer, IF/ID unchanged, pc unchanged, next state HOLD.
REQ-016 In FETCH with imem_ready=0 and !redirect: if !stall, IF/ID <= bubble; else IF/ID is held; pc is unchanged.
REQ-017 In FETCH with redirect and imem_ready=1: data is discarded, pc <= target, IF/ID <= bubble, remain in FETCH.
REQ-018 In FETCH with redirect and imem_ready=0: target goes to the redirect register, IF/ID <= bubble, next state DRAIN.
REQ-019 In HOLD, SHALL drive imem_req=0; on !stall: IF/ID <= {hold, pc+4, 1}, pc <= pc+4, next state FETCH; on redirect: hold is dropped, pc <= target, IF/ID <= bubble, next state FETCH.
REQ-020 In DRAIN, SHALL keep imem_req=1 at the old address; on imem_ready: data discarded, pc <= redirect register, next state FETCH; a new redirect in DRAIN SHALL overwrite the redirect register; IF/ID SHALL be a bubble whenever IFID_write=1.
REQ-021 A bubble SHALL be IFID_inst=32'h0 (NOP), IFID_pc4=32'h0, IFID_valid=0.
REQ-022 pc+4 SHALL be a 32-bit wrapping add (32'hFFFF_FFFC + 4 = 0).
REQ-023 Fetch latency SHALL be that the instruction is visible at IF/ID on the edge where imem_ready=1, with no extra cycle.

Reset
REQ-024 On rst_n=0, asynchronously: pc=RESET_PC, state=FETCH, IF/ID=bubble, hold, redirect register and all other internal registers = 0.
REQ-025 Reset mid-request SHALL abandon the transaction; after release, SHALL fetch RESET_PC.

Structure
REQ-026 Package if_pkg SHALL hold the state enum, the PC_SRC_SEQ/BR/J/RSV constants and NOP_INST.
REQ-027 SHALL have one sub-module, ifid_reg (32+32+1 register with write enable and bubble-load inputs).

Verification
REQ-028 Reset, then imem_ready=1 every cycle -> imem_addr 0,4,8,12; IFID_pc4 4,8,12.
REQ-029 pc=8, ready=1, IFID_write=pc_write=0 for 2 cycles -> state HOLD, imem_req=0, IF/ID held; release -> IFID_inst=word@8, IFID_pc4=12, next addr 12.
REQ-030 pc=16, ready=1, pc_src=01, branch_target=0x40 -> IFID_valid=0, next imem_addr=0x40.
REQ-031 pc=20, ready=0, pc_src=10, jump_target=0x100 -> DRAIN, imem_addr stays 20; ready after 3 cycles -> data dropped, next addr 0x100.
REQ-032 Simultaneous stall and pc_src=01 in HOLD -> hold dropped, bubble, pc=branch_target.
REQ-033 pc=0xFFFF_FFFC fetched -> IFID_pc4=0 and next addr 0; rst_n pulse mid-DRAIN -> addr RESET_PC.
